// File: rtl/dtp_uart_tx_pkg.sv
// Shared UART framing constants, FSM state encoding and parity helper.
// Also consumed by the command FSM for CR/LF message terminators.
package dtp_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_ACK    = 3'd5
  } tx_state_e;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/dtp_uart_tx_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled, strobes bit_end_o on the last count.
// Synchronous clear holds the counter at zero between frames.
module dtp_baud_gen #(
  parameter int BAUD_DIV = 868
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/dtp_uart_tx.sv
// UART transmitter: latches a byte on TX_RDY_T in IDLE, sends start/8 data LSB-first/parity/stop,
// then pulses TX_RDY_R for one cycle. IDLE never samples in the ACK cycle, giving a 2-cycle gap.
module dtp_uart_tx
  import dtp_uart_tx_pkg::*;
#(
  parameter int BAUD_DIV   = 868,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_RDY_T,
  input  logic [7:0] TX_DATA_T,
  output logic       TX_RDY_R,
  output logic       TXD,
  output logic       BUSY
);

  localparam logic       PAR_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_e  state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       parity_q;
  logic       txd_q;
  logic       rdy_q;
  logic       busy_q;

  logic baud_run;
  logic bit_end;

  assign baud_run = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP);

  dtp_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk_i     (CLK),
    .rst_i     (RST),
    .en_i      (baud_run),
    .clr_i     (!baud_run),
    .bit_end_o (bit_end)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      txd_q     <= UART_STOP_BIT;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          txd_q <= UART_STOP_BIT;
          if (TX_RDY_T) begin
            shift_q   <= TX_DATA_T;
            parity_q  <= calc_parity(TX_DATA_T, PAR_MODE);
            bit_cnt_q <= '0;
            txd_q     <= UART_START_BIT;
            busy_q    <= 1'b1;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            txd_q   <= shift_q[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              if (PARITY_EN != 0) begin
                txd_q   <= parity_q;
                state_q <= ST_PARITY;
              end else begin
                txd_q   <= UART_STOP_BIT;
                state_q <= ST_STOP;
              end
            end else begin
              // txd shows shift_q[0] now; the next bit is one position up.
              txd_q     <= shift_q[1];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            txd_q   <= UART_STOP_BIT;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (bit_cnt_q == LAST_STOP) begin
              rdy_q   <= 1'b1;
              state_q <= ST_ACK;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        ST_ACK: begin
          txd_q   <= UART_STOP_BIT;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          txd_q     <= UART_STOP_BIT;
          busy_q    <= 1'b0;
          bit_cnt_q <= '0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign TXD      = txd_q;
  assign TX_RDY_R = rdy_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_dtp_uart_tx.sv
// Bench for dtp_uart_tx: three parameter variants, a per-cycle waveform model per instance,
// plus directed frame-length / parity / byte-capture checks and randomized frames.
module tb_dtp_uart_tx;
  import dtp_uart_tx_pkg::*;

  localparam int DIV    = 4;
  localparam int PE [3] = '{1, 1, 0};
  localparam int ODD[3] = '{0, 1, 0};
  localparam int SB [3] = '{1, 2, 1};

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       rdy_t[3];
  logic [7:0] dat_t[3];
  logic       txd[3];
  logic       rdyr[3];
  logic       busy[3];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  dtp_uart_tx #(.BAUD_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .CLK(CLK), .RST(RST), .TX_RDY_T(rdy_t[0]), .TX_DATA_T(dat_t[0]),
    .TX_RDY_R(rdyr[0]), .TXD(txd[0]), .BUSY(busy[0]));

  dtp_uart_tx #(.BAUD_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut1 (
    .CLK(CLK), .RST(RST), .TX_RDY_T(rdy_t[1]), .TX_DATA_T(dat_t[1]),
    .TX_RDY_R(rdyr[1]), .TXD(txd[1]), .BUSY(busy[1]));

  dtp_uart_tx #(.BAUD_DIV(DIV), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut2 (
    .CLK(CLK), .RST(RST), .TX_RDY_T(rdy_t[2]), .TX_DATA_T(dat_t[2]),
    .TX_RDY_R(rdyr[2]), .TXD(txd[2]), .BUSY(busy[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-instance model: a queue of expected {TXD, TX_RDY_R, BUSY} per cycle, filled
  // with a whole frame when a request is seen after a full idle cycle.
  for (genvar g = 0; g < 3; g++) begin : g_model
    logic [2:0] q[$];
    logic [2:0] cur = 3'b100;
    bit         cur_idle = 1'b1;
    int         ones;
    bit         par;
    bit         v;

    always @(posedge CLK or posedge RST) begin
      if (RST) begin
        q.delete();
        cur      = 3'b100;
        cur_idle = 1'b1;
      end else begin
        if (cur_idle && rdy_t[g] === 1'b1) begin
          ones = 0;
          for (int i = 0; i < 8; i++) ones += int'(dat_t[g][i]);
          par = ((ones % 2) == 1) ^ (ODD[g] != 0);
          for (int s = 0; s < 9 + PE[g] + SB[g]; s++) begin
            if (s == 0)                      v = 1'b0;
            else if (s <= 8)                 v = dat_t[g][s-1];
            else if (PE[g] != 0 && s == 9)   v = par;
            else                             v = 1'b1;
            repeat (DIV) q.push_back({v, 1'b0, 1'b1});
          end
          q.push_back(3'b111);
        end
        if (q.size() > 0) begin
          cur      = q.pop_front();
          cur_idle = 1'b0;
        end else begin
          cur      = 3'b100;
          cur_idle = 1'b1;
        end
      end
    end

    always @(negedge CLK) begin
      if (chk_en) begin
        n_chk++;
        if ({txd[g], rdyr[g], busy[g]} !== cur) begin
          n_fail++;
          $display("FAIL model_cmp[%0d] @%0t: {txd,rdy_r,busy} got %b expected %b",
                   g, $time, {txd[g], rdyr[g], busy[g]}, cur);
        end
      end
    end
  end

  // Called at the negedge of the first start cycle; follows the frame to its ACK.
  // ack_act: 0 nothing, 1 drop request at ACK, 2 present nxt at ACK (request kept).
  task automatic watch_frame(input int g, input logic [7:0] b, input int exp_len,
                             input int par_exp, input bit chg, input int ack_act,
                             input logic [7:0] nxt);
    int         n;
    logic [7:0] got;
    got = '0;
    n   = 0;
    while (rdyr[g] !== 1'b1 && n < 200) begin
      if (n % DIV == 2) begin
        if (n / DIV >= 1 && n / DIV <= 8) got[n/DIV - 1] = txd[g];
        if (n / DIV == 9 && par_exp >= 0) check("parity_bit", 32'(txd[g]), 32'(par_exp));
      end
      if (chg && n == 14) begin
        dat_t[g] = ~b;
        rdy_t[g] = 1'b0;
      end
      @(negedge CLK);
      n++;
    end
    check("frame_len", 32'(n), 32'(exp_len));
    check("rx_byte", 32'(got), 32'(b));
    if (ack_act == 1) rdy_t[g] = 1'b0;
    if (ack_act == 2) dat_t[g] = nxt;
    @(negedge CLK);
    check("ack_one_cycle", 32'(rdyr[g]), 32'd0);
  endtask

  task automatic run_frame(input int g, input logic [7:0] b, input int par_exp, input bit chg);
    @(negedge CLK);
    dat_t[g] = b;
    rdy_t[g] = 1'b1;
    @(negedge CLK);
    check("start_latency", 32'(txd[g]), 32'd0);
    if (!chg) rdy_t[g] = 1'b0;
    watch_frame(g, b, (9 + PE[g] + SB[g]) * DIV, par_exp, chg, 0, 8'h00);
  endtask

  initial begin
    int lows;
    for (int g = 0; g < 3; g++) begin
      rdy_t[g] = 1'b0;
      dat_t[g] = 8'h00;
    end
    #1 RST = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_txd", 32'(txd[0]), 32'd1);
    check("reset_rdy_r", 32'(rdyr[0]), 32'd0);
    check("reset_busy", 32'(busy[2]), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // 8'h41, even parity (two ones -> 0), 44-cycle frame
    run_frame(0, 8'h41, 0, 1'b0);

    // Reset during DATA bit 3
    @(negedge CLK);
    dat_t[0] = 8'h41;
    rdy_t[0] = 1'b1;
    @(negedge CLK);
    check("rst_test_start", 32'(txd[0]), 32'd0);
    repeat (17) @(negedge CLK);
    check("rst_test_busy_before", 32'(busy[0]), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("midframe_rst_txd", 32'(txd[0]), 32'd1);
    check("midframe_rst_rdy_r", 32'(rdyr[0]), 32'd0);
    check("midframe_rst_busy", 32'(busy[0]), 32'd0);
    rdy_t[0] = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    run_frame(0, 8'h41, 0, 1'b0);

    // Odd parity, two stop bits: 8'hFF -> parity 1, 48 cycles
    run_frame(1, 8'hFF, 1, 1'b0);

    // FSM-style CR then LF with the request held high
    @(negedge CLK);
    dat_t[0] = ASCII_CR;
    rdy_t[0] = 1'b1;
    @(negedge CLK);
    check("msg_cr_start", 32'(txd[0]), 32'd0);
    watch_frame(0, ASCII_CR, 44, 1, 1'b0, 2, ASCII_LF);
    @(negedge CLK);
    check("msg_gap_2_cycles", 32'(txd[0]), 32'd0);
    watch_frame(0, ASCII_LF, 44, 0, 1'b0, 1, 8'h00);
    lows = 0;
    repeat (60) begin
      @(negedge CLK);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
    end
    check("msg_no_third_frame", 32'(lows), 32'd0);

    // Data change and request drop mid-frame: 8'h55 must go out intact
    run_frame(0, 8'h55, 0, 1'b1);
    lows = 0;
    repeat (20) begin
      @(negedge CLK);
      if (txd[0] !== 1'b1) lows++;
    end
    check("stay_idle_after_drop", 32'(lows), 32'd0);

    // No parity: 8'h00 -> 9 low bit periods + stop, 40 cycles
    run_frame(2, 8'h00, -1, 1'b0);

    // Randomized frames across all variants
    for (int k = 0; k < 24; k++) begin
      int          gi;
      logic [7:0]  rb;
      gi = int'($urandom_range(0, 2));
      rb = 8'($urandom);
      run_frame(gi, rb, -1, 1'($urandom_range(0, 1)));
      repeat (int'($urandom_range(0, 3))) @(negedge CLK);
    end

    repeat (4) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dtp_uart_tx.md
Name: dtp_uart_tx

Overview:
- Parallel-to-serial UART transmitter (DTP): the responder on the TX_RDY_T / TX_DATA_T / TX_RDY_R handshake driven by the command FSM.
- Latches one byte per handshake, serialises it on TXD as start, 8 data bits LSB-first, optional parity, then stop bit(s).
- Returns a one-cycle TX_RDY_R pulse when the frame is fully on the line.
- Sits between the command FSM and the board TX pin; mirror of the STP receiver.

Parameters:
- BAUD_DIV, 868: clock cycles per bit (100 MHz / 115200); must be >= 2.
- PARITY_EN, 1: 1 = append parity bit after data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- CLK  input  1  system clock; single clock domain.
- RST  input  1  asynchronous, active-high reset.
- TX_RDY_T  input  1  level request from FSM: a byte is valid on TX_DATA_T; held high for a whole message.
- TX_DATA_T  input  8  byte to send; sampled only in IDLE.
- TX_RDY_R  output  1  one-cycle pulse: current byte fully transmitted, present next byte.
- TXD  output  1  serial line, registered; idle high.
- BUSY  output  1  high from frame start through the ACK cycle.

Behaviour:
- Reset (async, any state, including mid-frame): TXD=1, TX_RDY_R=0, BUSY=0, state=IDLE, baud counter=0, bit counter=0, shift register=0. A frame interrupted by reset is abandoned; the line returns high immediately.
- Baud counter runs 0..BAUD_DIV-1 while not IDLE/ACK. A bit period ends when the counter = BAUD_DIV-1; the counter then wraps to 0. Every bit lasts exactly BAUD_DIV cycles.
- States:
  - IDLE: TXD=1. If TX_RDY_T=1 at the edge: latch TX_DATA_T into shift register, compute parity (XOR of 8 bits, inverted if PARITY_ODD), TXD<=0, BUSY<=1, go START.
  - START: hold TXD=0 for one bit period, then TXD<=data[0], go DATA.
  - DATA: 8 bit periods, shifting LSB-first; bit counter 0..7. After bit 7, go PARITY (TXD<=parity) if PARITY_EN, else STOP (TXD<=1).
  - PARITY: one bit period, then TXD<=1, go STOP.
  - STOP: STOP_BITS bit periods at TXD=1, then go ACK.
  - ACK: TX_RDY_R=1 for exactly this cycle; TXD=1; BUSY<=0 on exit; go IDLE unconditionally.
- IDLE must not sample in the ACK cycle. The FSM updates TX_DATA_T / TX_RDY_T on the edge where it sees the pulse, so the next sample happens one cycle later.
- Latency: TX_RDY_T high in IDLE -> TXD low on the next edge.
- Frame length from the first start cycle to the last stop cycle is (9 + PARITY_EN + STOP_BITS) * BAUD_DIV cycles. The ACK pulse follows in the next cycle.
- Back-to-back: with TX_RDY_T held high, the inter-frame idle gap is exactly 2 cycles (ACK + IDLE sample).
- TX_RDY_T dropped mid-frame: the frame completes and TX_RDY_R still pulses. TX_RDY_T low in IDLE: no frame starts.
- TX_DATA_T changing mid-frame: ignored; the latched byte is sent.
- TX_RDY_T dropping in the same cycle as TX_RDY_R (end of message): no further frame starts.
- Default state encoding: any illegal state -> IDLE with TXD=1.

Decomposition:
- Shared package: state encoding localparams; UART framing constants (start=0, stop=1); ASCII CR 8'h0D and LF 8'h0A, also used by the FSM; parity-mode constants.
- One natural sub-module: dtp_baud_gen. Counter 0..BAUD_DIV-1 with enable and synchronous clear, producing a bit_end strobe. The main block keeps the frame FSM, shift register and parity.

Test Plan:
(sim with BAUD_DIV=4, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=1 unless noted)
- Reset check: assert RST mid-frame (during DATA bit 3) -> TXD=1, TX_RDY_R=0 and BUSY=0 within the same cycle, no ACK pulse; after release, a new TX_RDY_T=1 starts a clean frame.
- Single byte 8'h41: TXD = 0,1,0,0,0,0,0,1,0,0 (parity), 1, each held 4 cycles. Frame = 44 cycles from the first low, TX_RDY_R pulses once in the following cycle.
- Odd parity, 2 stops (PARITY_ODD=1, STOP_BITS=2), byte 8'hFF: parity bit = 1, two stop periods (8 cycles high), frame = 48 cycles.
- FSM-style message 8'h0D then 8'h0A: TX_RDY_T held high, FSM model updates data on the TX_RDY_R edge -> two frames separated by exactly 2 idle cycles; the second frame carries 8'h0A. TX_RDY_T low on the second ACK -> no third frame.
- Data change and request drop mid-frame: change TX_DATA_T from 8'h55 to 8'hAA during DATA and deassert TX_RDY_T -> 8'h55 sent intact, TX_RDY_R still pulses, IDLE stays idle afterwards.
- No parity (PARITY_EN=0), byte 8'h00: 9 low bit periods then 1 stop. Frame = 40 cycles; no parity slot.
